// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: grants one of two requesters per cycle onto the register file write port.
// Define RF_WB_ROUND_ROBIN_EN for round-robin conflict resolution; fixed priority (req0 wins) otherwise.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] Bus_W,
    output logic          reg_write,
    output logic [CW-1:0] wr_count
);

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_xfer;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;
    logic          w_commit;

    logic [AW-1:0] r_rw;
    logic [DW-1:0] r_bus_w;
    logic          r_reg_write;
    logic [CW-1:0] r_wr_count;

`ifdef RF_WB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Under contention the requester opposite to the previous grant wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n && !hold) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_gnt1;
        end
    end
`else
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n && !hold) begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid && !req0_valid;
        end
    end
`endif

    assign w_xfer     = w_gnt0 || w_gnt1;
    assign w_sel_addr = w_gnt1 ? req1_addr : req0_addr;
    assign w_sel_data = w_gnt1 ? req1_data : req0_data;
    // R0 writes are accepted but never reach the register file.
    assign w_commit   = w_xfer && (w_sel_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw        <= '0;
            r_bus_w     <= '0;
            r_reg_write <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            r_reg_write <= w_commit;
            if (w_xfer) begin
                r_rw    <= w_sel_addr;
                r_bus_w <= w_sel_data;
            end
            if (w_commit) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign RW         = r_rw;
    assign Bus_W      = r_bus_w;
    assign reg_write  = r_reg_write;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter against a transaction-level reference model.
// Honours RF_WB_ROUND_ROBIN_EN the same way the design does.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          hold;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] RW;
    logic [DW-1:0] Bus_W;
    logic          reg_write;
    logic [CW-1:0] wr_count;

    rf_wb_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .RW(RW), .Bus_W(Bus_W), .reg_write(reg_write), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the register file write port should show after each edge.
    int            m_last;
    logic [AW-1:0] m_rw;
    logic [DW-1:0] m_bw;
    logic          m_we;
    int            m_cnt;
    int            last_g;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_rw   = '0;
        m_bw   = '0;
        m_we   = 1'b0;
        m_cnt  = 0;
        last_g = -1;
    endtask

    // One clock: check readies mid-cycle, then check registered outputs just after the edge.
    task automatic cycle();
        int g;
        @(negedge clk);
        g = -1;
        if (!hold) begin
            if (req0_valid && req1_valid) begin
`ifdef RF_WB_ROUND_ROBIN_EN
                g = (m_last == 0) ? 1 : 0;
`else
                g = 0;
`endif
            end else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        check_eq("req0_ready", 64'(req0_ready), 64'(g == 0));
        check_eq("req1_ready", 64'(req1_ready), 64'(g == 1));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_rw   = (g == 1) ? req1_addr : req0_addr;
            m_bw   = (g == 1) ? req1_data : req0_data;
            m_we   = (m_rw != 0);
            if (m_we) m_cnt = (m_cnt + 1) % (1 << CW);
            m_last = g;
        end else begin
            m_we = 1'b0;
        end
        last_g = g;
        check_eq("RW", 64'(RW), 64'(m_rw));
        check_eq("Bus_W", 64'(Bus_W), 64'(m_bw));
        check_eq("reg_write", 64'(reg_write), 64'(m_we));
        check_eq("wr_count", 64'(wr_count), 64'(m_cnt));
    endtask

    // Asynchronous reset mid-cycle with both requesters valid.
    task automatic apply_reset();
        #2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        hold       = 1'b0;
        rst_n      = 1'b0;
        #1;
        model_reset();
        check_eq("rst_RW", 64'(RW), 64'd0);
        check_eq("rst_Bus_W", 64'(Bus_W), 64'd0);
        check_eq("rst_reg_write", 64'(reg_write), 64'd0);
        check_eq("rst_wr_count", 64'(wr_count), 64'd0);
        check_eq("rst_ready0", 64'(req0_ready), 64'd0);
        check_eq("rst_ready1", 64'(req1_ready), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic pend0, pend1;

    initial begin
        rst_n = 1'b0;
        hold = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        req0_data = '0; req1_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester write
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA5;
        cycle();
        req0_valid = 1'b0;
        cycle();
        check_eq("single_count", 64'(wr_count), 64'd1);

        // Write to R0 is accepted and discarded
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFF;
        cycle();
        check_eq("r0_reg_write", 64'(reg_write), 64'd0);
        req1_valid = 1'b0;
        cycle();
        check_eq("r0_count", 64'(wr_count), 64'd1);

        // Contention after a mid-cycle reset
        apply_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        repeat (4) cycle();
        check_eq("contend_count", 64'(wr_count), 64'd4);
        req0_valid = 1'b0;
        cycle();
        req1_valid = 1'b0;
        cycle();

        // Hold blocks grants, release grants on the next cycle
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hC0DE;
        hold = 1'b1;
        repeat (3) cycle();
        hold = 1'b0;
        cycle();
        check_eq("hold_grant_RW", 64'(RW), 64'd7);
        req0_valid = 1'b0;
        cycle();

        // Random traffic obeying the valid/ready protocol
        pend0 = 1'b0; pend1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (last_g == 0) pend0 = 1'b0;
            if (last_g == 1) pend1 = 1'b0;
            if (!pend0 && ($urandom % 3 != 0)) begin
                pend0 = 1'b1;
                req0_addr = AW'($urandom % 8 == 0 ? 0 : $urandom);
                req0_data = $urandom;
            end
            if (!pend1 && ($urandom % 3 != 0)) begin
                pend1 = 1'b1;
                req1_addr = AW'($urandom % 8 == 0 ? 0 : $urandom);
                req1_data = $urandom;
            end
            req0_valid = pend0;
            req1_valid = pend1;
            hold = ($urandom % 5 == 0);
            cycle();
        end
        hold = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();

        // Counter wraps after 2^CW committed writes
        apply_reset();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
        for (int i = 0; i < (1 << CW); i++) begin
            req0_data = 32'(i);
            cycle();
        end
        req0_valid = 1'b0;
        cycle();
        check_eq("wrap_count", 64'(wr_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
